// File: rtl/fp_control_unit.sv
// Sequencing FSM for the single-precision FP datapath: walks an add or multiply
// through exponent compare, mantissa alignment, execute, normalization and
// write-back, driving every datapath select, opcode, shift and load enable.
module fp_control_unit #(
  parameter int unsigned MUL_TIMEOUT = 64,
  parameter int unsigned NORM_MAX    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] exp_a,
  input  logic [7:0] exp_b,
  input  logic       end_multiplication,
  input  logic       finalize_operation,
  input  logic       norm_overflow,
  output logic       mux01_sel,
  output logic       mux02_sel,
  output logic       mux03_sel,
  output logic       mux04_sel,
  output logic       mux05_sel,
  output logic       mux06_sel,
  output logic [7:0] shift_right_amt,
  output logic [4:0] shift_norm_amt,
  output logic [3:0] small_alu_op,
  output logic       small_mux_a,
  output logic       small_mux_b,
  output logic       load_reg_small,
  output logic [3:0] big_alu_op,
  output logic       big_mux_a,
  output logic       big_mux_b,
  output logic       big_mux_c,
  output logic       sum_or_mul,
  output logic       load_reg_a,
  output logic       load_reg_b,
  output logic [3:0] incdec_op,
  output logic       incdec_en,
  output logic       load_final,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MulCntW  = $clog2(MUL_TIMEOUT + 1);
  localparam int unsigned NormCntW = $clog2(NORM_MAX + 1);

  // Mantissa alignment never needs more than the 24-bit significand width.
  localparam logic [7:0] ShiftSat = 8'd24;

  localparam logic [3:0] SmallOpSub    = 4'b0110;
  localparam logic [3:0] SmallOpAddExp = 4'b0011;
  localparam logic [3:0] BigOpAdd      = 4'b0010;
  localparam logic [3:0] BigOpMul      = 4'b0011;
  localparam logic [3:0] IncDecInc     = 4'b0001;
  localparam logic [3:0] IncDecDec     = 4'b0010;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StShift,
    StExec,
    StMulWait,
    StNorm,
    StWrite,
    StDone
  } state_t;

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic                a_small_q, a_small_d;
  logic [7:0]          shamt_q, shamt_d;
  logic [MulCntW-1:0]  mul_cnt_q, mul_cnt_d;
  logic [NormCntW-1:0] norm_cnt_q, norm_cnt_d;
  logic                err_q, err_d;

  logic [7:0] exp_diff;
  logic [7:0] exp_diff_sat;
  logic       mul_timeout;
  logic       norm_limit;
  logic       norm_iter;

  // Exponent distance and the status decodes shared by next-state and outputs.
  always_comb begin
    exp_diff     = (exp_a >= exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);
    exp_diff_sat = (exp_diff > ShiftSat) ? ShiftSat : exp_diff;
    // The current MUL_WAIT cycle is the last one allowed.
    mul_timeout  = (mul_cnt_q == MulCntW'(MUL_TIMEOUT - 1));
    norm_limit   = (norm_cnt_q == NormCntW'(NORM_MAX));
    // An iteration runs only while the rounder still asks for one and budget remains.
    norm_iter    = finalize_operation && !norm_limit;
  end

  // State and datapath-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= 1'b0;
      a_small_q  <= 1'b0;
      shamt_q    <= 8'd0;
      mul_cnt_q  <= '0;
      norm_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_small_q  <= a_small_d;
      shamt_q    <= shamt_d;
      mul_cnt_q  <= mul_cnt_d;
      norm_cnt_q <= norm_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic and counter / error bookkeeping.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_small_d  = a_small_q;
    shamt_d    = shamt_q;
    mul_cnt_d  = mul_cnt_q;
    norm_cnt_d = norm_cnt_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d       = op;
          err_d      = 1'b0;
          mul_cnt_d  = '0;
          norm_cnt_d = '0;
          state_d    = StAlign;
        end
      end
      StAlign: begin
        // Ties count as A-small so the B path is treated as the larger operand.
        a_small_d = (exp_a <= exp_b);
        shamt_d   = op_q ? 8'd0 : exp_diff_sat;
        state_d   = StShift;
      end
      StShift: begin
        state_d = StExec;
      end
      StExec: begin
        state_d = op_q ? StMulWait : StNorm;
      end
      StMulWait: begin
        // Completion takes priority over a timeout in the same cycle.
        if (end_multiplication) begin
          state_d = StNorm;
        end else if (mul_timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          mul_cnt_d = mul_cnt_q + MulCntW'(1);
        end
      end
      StNorm: begin
        if (!finalize_operation) begin
          state_d = StWrite;
        end else if (norm_limit) begin
          err_d   = 1'b1;
          state_d = StWrite;
        end else begin
          norm_cnt_d = norm_cnt_q + NormCntW'(1);
        end
      end
      StWrite: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    mux01_sel       = 1'b0;
    mux02_sel       = 1'b0;
    mux03_sel       = 1'b0;
    mux04_sel       = 1'b0;
    mux05_sel       = 1'b0;
    mux06_sel       = 1'b0;
    shift_right_amt = 8'd0;
    shift_norm_amt  = 5'd0;
    small_alu_op    = 4'd0;
    small_mux_a     = 1'b0;
    small_mux_b     = 1'b0;
    load_reg_small  = 1'b0;
    big_alu_op      = 4'd0;
    big_mux_a       = 1'b0;
    big_mux_b       = 1'b0;
    big_mux_c       = 1'b0;
    sum_or_mul      = 1'b0;
    load_reg_a      = 1'b0;
    load_reg_b      = 1'b0;
    incdec_op       = 4'd0;
    incdec_en       = 1'b0;
    load_final      = 1'b0;
    busy            = (state_q != StIdle);
    done            = 1'b0;
    err             = err_q;

    unique case (state_q)
      StIdle: ;
      StAlign: begin
        small_alu_op   = op_q ? SmallOpAddExp : SmallOpSub;
        load_reg_small = 1'b1;
      end
      StShift: begin
        // Route the smaller mantissa through the alignment shifter.
        mux01_sel       = !a_small_q;
        mux03_sel       = !a_small_q;
        mux04_sel       = a_small_q;
        shift_right_amt = shamt_q;
        load_reg_a      = 1'b1;
        load_reg_b      = 1'b1;
      end
      StExec: begin
        big_alu_op = op_q ? BigOpMul : BigOpAdd;
        sum_or_mul = op_q;
      end
      StMulWait: begin
        big_alu_op = BigOpMul;
        sum_or_mul = 1'b1;
      end
      StNorm: begin
        // Iteration strobes follow the rounder's live request within the cycle.
        if (norm_iter) begin
          incdec_en      = 1'b1;
          shift_norm_amt = 5'd1;
          incdec_op      = norm_overflow ? IncDecInc : IncDecDec;
          // After the first pass the normalizer consumes its own previous result.
          mux05_sel      = (norm_cnt_q != '0);
          mux02_sel      = (norm_cnt_q != '0);
        end
      end
      StWrite: begin
        load_final = 1'b1;
        // An unnormalized product is written straight from the multiplier.
        mux06_sel  = op_q && (norm_cnt_q == '0);
      end
      StDone: begin
        done = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_control_unit.sv
// Self-checking bench for fp_control_unit: a phase-timeline reference model
// predicts the full control vector every cycle for directed and random operations.
module tb_fp_control_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic       end_multiplication;
  logic       finalize_operation;
  logic       norm_overflow;
  logic       mux01_sel, mux02_sel, mux03_sel, mux04_sel, mux05_sel, mux06_sel;
  logic [7:0] shift_right_amt;
  logic [4:0] shift_norm_amt;
  logic [3:0] small_alu_op;
  logic       small_mux_a, small_mux_b, load_reg_small;
  logic [3:0] big_alu_op;
  logic       big_mux_a, big_mux_b, big_mux_c, sum_or_mul, load_reg_a, load_reg_b;
  logic [3:0] incdec_op;
  logic       incdec_en, load_final, busy, done, err;

  typedef struct packed {
    logic       m01, m02, m03, m04, m05, m06;
    logic [7:0] shr;
    logic [4:0] shn;
    logic [3:0] salu;
    logic       sma, smb, lrs;
    logic [3:0] balu;
    logic       bma, bmb, bmc, som, lra, lrb;
    logic [3:0] ido;
    logic       ide, lf, bsy, dn, er;
  } ctl_t;

  localparam int PH_IDLE  = 0;
  localparam int PH_ALIGN = 1;
  localparam int PH_SHIFT = 2;
  localparam int PH_EXEC  = 3;
  localparam int PH_MULW  = 4;
  localparam int PH_NORM  = 5;
  localparam int PH_WRITE = 6;
  localparam int PH_DONE  = 7;

  localparam int MulTimeout = 64;
  localparam int NormMax    = 24;

  int   errors = 0;
  int   checks = 0;
  bit   model_err = 1'b0;
  ctl_t act;

  assign act = {mux01_sel, mux02_sel, mux03_sel, mux04_sel, mux05_sel, mux06_sel,
                shift_right_amt, shift_norm_amt, small_alu_op, small_mux_a, small_mux_b,
                load_reg_small, big_alu_op, big_mux_a, big_mux_b, big_mux_c, sum_or_mul,
                load_reg_a, load_reg_b, incdec_op, incdec_en, load_final, busy, done, err};

  fp_control_unit #(
    .MUL_TIMEOUT(MulTimeout),
    .NORM_MAX   (NormMax)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .op                (op),
    .exp_a             (exp_a),
    .exp_b             (exp_b),
    .end_multiplication(end_multiplication),
    .finalize_operation(finalize_operation),
    .norm_overflow     (norm_overflow),
    .mux01_sel         (mux01_sel),
    .mux02_sel         (mux02_sel),
    .mux03_sel         (mux03_sel),
    .mux04_sel         (mux04_sel),
    .mux05_sel         (mux05_sel),
    .mux06_sel         (mux06_sel),
    .shift_right_amt   (shift_right_amt),
    .shift_norm_amt    (shift_norm_amt),
    .small_alu_op      (small_alu_op),
    .small_mux_a       (small_mux_a),
    .small_mux_b       (small_mux_b),
    .load_reg_small    (load_reg_small),
    .big_alu_op        (big_alu_op),
    .big_mux_a         (big_mux_a),
    .big_mux_b         (big_mux_b),
    .big_mux_c         (big_mux_c),
    .sum_or_mul        (sum_or_mul),
    .load_reg_a        (load_reg_a),
    .load_reg_b        (load_reg_b),
    .incdec_op         (incdec_op),
    .incdec_en         (incdec_en),
    .load_final        (load_final),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for one cycle of a given phase.
  function automatic ctl_t model_out(input int ph, input int iter, input bit opv,
                                     input logic [7:0] ea, input logic [7:0] eb,
                                     input int iters_total, input bit ovf, input bit errv);
    ctl_t e;
    int   diff;
    e     = '0;
    e.bsy = (ph != PH_IDLE);
    e.er  = errv;
    diff  = (int'(ea) > int'(eb)) ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
    case (ph)
      PH_ALIGN: begin
        e.salu = opv ? 4'b0011 : 4'b0110;
        e.lrs  = 1'b1;
      end
      PH_SHIFT: begin
        e.m01 = (ea > eb);
        e.m03 = (ea > eb);
        e.m04 = (ea <= eb);
        e.shr = opv ? 8'd0 : 8'((diff > 24) ? 24 : diff);
        e.lra = 1'b1;
        e.lrb = 1'b1;
      end
      PH_EXEC: begin
        e.balu = opv ? 4'b0011 : 4'b0010;
        e.som  = opv;
      end
      PH_MULW: begin
        e.balu = 4'b0011;
        e.som  = 1'b1;
      end
      PH_NORM: begin
        if (iter >= 0) begin
          e.ide = 1'b1;
          e.shn = 5'd1;
          e.ido = ovf ? 4'b0001 : 4'b0010;
          e.m05 = (iter >= 1);
          e.m02 = (iter >= 1);
        end
      end
      PH_WRITE: begin
        e.lf  = 1'b1;
        e.m06 = opv && (iters_total == 0);
      end
      PH_DONE: e.dn = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // One operation launched from IDLE. k: cycle of MUL_WAIT where completion is
  // seen (0 = never). n: NORM cycles with finalize high. start_mode: 0 quiet,
  // 1 random, 2 held high while busy. abort_at: cycle to pulse reset (0 = none).
  task automatic run_txn(input string name, input bit opv, input logic [7:0] ea,
                         input logic [7:0] eb, input int k, input int n,
                         input int start_mode, input int abort_at);
    int   ph_q[$];
    int   err_from;
    int   iters_total;
    int   mw;
    int   nidx;
    int   iter;
    bit   ovf;
    bit   errv;
    ctl_t e;

    err_from    = -1;
    iters_total = (n > NormMax) ? NormMax : n;
    ph_q.push_back(PH_ALIGN);
    ph_q.push_back(PH_SHIFT);
    ph_q.push_back(PH_EXEC);
    if (opv && k == 0) begin
      repeat (MulTimeout) ph_q.push_back(PH_MULW);
      err_from = ph_q.size();
      ph_q.push_back(PH_DONE);
    end else begin
      if (opv) repeat (k) ph_q.push_back(PH_MULW);
      repeat ((n > NormMax) ? NormMax + 1 : n + 1) ph_q.push_back(PH_NORM);
      if (n > NormMax) err_from = ph_q.size();
      ph_q.push_back(PH_WRITE);
      ph_q.push_back(PH_DONE);
    end

    @(negedge clk);
    start              = 1'b1;
    op                 = opv;
    exp_a              = ea;
    exp_b              = eb;
    end_multiplication = 1'($urandom_range(0, 1));
    finalize_operation = 1'($urandom_range(0, 1));
    norm_overflow      = 1'($urandom_range(0, 1));
    #1;
    e = model_out(PH_IDLE, -1, 1'b0, ea, eb, 0, 1'b0, model_err);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s idle cycle=0 actual=%h expected=%h", name, act, e);
    end

    mw   = 0;
    nidx = 0;
    for (int i = 0; i < ph_q.size(); i++) begin
      @(negedge clk);
      if (i + 1 == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
          if (r > 0) @(negedge clk);
          #1;
          checks++;
          if (act !== ctl_t'('0)) begin
            errors++;
            $display("FAIL %s reset_abort step=%0d actual=%h expected=%h", name, r, act,
                     ctl_t'('0));
          end
        end
        @(negedge clk);
        rst_n     = 1'b1;
        model_err = 1'b0;
        return;
      end
      case (start_mode)
        2:       start = 1'b1;
        1:       start = 1'($urandom_range(0, 1));
        default: start = 1'b0;
      endcase
      iter = -1;
      if (ph_q[i] == PH_MULW) begin
        mw++;
        end_multiplication = (mw == k);
      end else begin
        end_multiplication = 1'($urandom_range(0, 1));
      end
      if (ph_q[i] == PH_NORM) begin
        finalize_operation = (nidx < n);
        if (nidx < n && nidx < NormMax) iter = nidx;
        nidx++;
      end else begin
        finalize_operation = 1'($urandom_range(0, 1));
      end
      ovf           = 1'($urandom_range(0, 1));
      norm_overflow = ovf;
      errv          = (err_from >= 0) && (i >= err_from);
      #1;
      e = model_out(ph_q[i], iter, opv, ea, eb, iters_total, ovf, errv);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s cycle=%0d phase=%0d actual=%h expected=%h", name, i + 1, ph_q[i],
                 act, e);
      end
    end
    model_err = (err_from >= 0);
  endtask

  // Quiet IDLE cycles: nothing may start and only the sticky error may show.
  task automatic idle_cycles(input string name, input int cnt);
    ctl_t e;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      start              = 1'b0;
      end_multiplication = 1'($urandom_range(0, 1));
      finalize_operation = 1'($urandom_range(0, 1));
      norm_overflow      = 1'($urandom_range(0, 1));
      #1;
      e = model_out(PH_IDLE, -1, 1'b0, 8'd0, 8'd0, 0, 1'b0, model_err);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s idle=%0d actual=%h expected=%h", name, i, act, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    start              = 1'b1;
    op                 = 1'b1;
    exp_a              = 8'd200;
    exp_b              = 8'd3;
    end_multiplication = 1'b1;
    finalize_operation = 1'b1;
    norm_overflow      = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (act !== ctl_t'('0)) begin
      errors++;
      $display("FAIL reset_hold actual=%h expected=%h", act, ctl_t'('0));
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (act !== ctl_t'('0)) begin
      errors++;
      $display("FAIL reset_release actual=%h expected=%h", act, ctl_t'('0));
    end
    model_err = 1'b0;
  endtask

  task automatic test_add_basic();
    run_txn("add_130_127", 1'b0, 8'd130, 8'd127, 0, 0, 0, 0);
    run_txn("add_sat", 1'b0, 8'd100, 8'd140, 0, 0, 0, 0);
    run_txn("add_equal", 1'b0, 8'd90, 8'd90, 0, 0, 0, 0);
    run_txn("add_diff24", 1'b0, 8'd24, 8'd0, 0, 0, 0, 0);
  endtask

  task automatic test_add_norm();
    run_txn("add_norm2", 1'b0, 8'd127, 8'd126, 0, 2, 0, 0);
    run_txn("add_norm_limit24", 1'b0, 8'd10, 8'd20, 0, NormMax, 0, 0);
    run_txn("add_norm_over", 1'b0, 8'd10, 8'd20, 0, NormMax + 5, 0, 0);
    idle_cycles("after_norm_err", 2);
  endtask

  task automatic test_mul();
    run_txn("mul_k10", 1'b1, 8'd130, 8'd120, 10, 0, 0, 0);
    run_txn("mul_k1_norm3", 1'b1, 8'd5, 8'd250, 1, 3, 0, 0);
    run_txn("mul_timeout", 1'b1, 8'd130, 8'd120, 0, 0, 0, 0);
    idle_cycles("after_timeout", 2);
    run_txn("mul_end_at_limit", 1'b1, 8'd1, 8'd2, MulTimeout, 0, 0, 0);
  endtask

  task automatic test_reset_mid_op();
    run_txn("mul_reset_abort", 1'b1, 8'd140, 8'd100, 20, 0, 0, 7);
    run_txn("add_after_reset", 1'b0, 8'd130, 8'd127, 0, 1, 0, 0);
  endtask

  task automatic test_start_busy();
    run_txn("add_start_held", 1'b0, 8'd60, 8'd61, 0, 1, 2, 0);
    idle_cycles("start_in_done", 2);
    run_txn("mul_start_held", 1'b1, 8'd60, 8'd61, 4, 0, 2, 0);
    idle_cycles("start_in_done_mul", 1);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_0", 1'b0, 8'd33, 8'd77, 0, 0, 1, 0);
    run_txn("b2b_1", 1'b1, 8'd77, 8'd33, 3, 1, 1, 0);
    run_txn("b2b_2", 1'b0, 8'd200, 8'd1, 0, 2, 1, 0);
  endtask

  task automatic test_random();
    logic [7:0] ea;
    logic [7:0] eb;
    bit         opv;
    int         k;
    int         n;
    for (int t = 0; t < 24; t++) begin
      opv = 1'($urandom_range(0, 1));
      ea  = 8'($urandom_range(0, 255));
      eb  = ($urandom_range(0, 3) == 0) ? ea : 8'($urandom_range(0, 255));
      k   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
      n   = ($urandom_range(0, 9) == 0) ? NormMax + 2 : $urandom_range(0, 4);
      run_txn("random", opv, ea, eb, k, n, 1, 0);
      idle_cycles("random_gap", $urandom_range(0, 2));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_basic();
    test_add_norm();
    test_mul();
    test_reset_mid_op();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
